// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and the request unit's state encoding.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {IDLE, DATA, HALT} reqstate_t;
endpackage

// File: rtl/request_unit_link_reg.sv
// LL/SC link register: one linked address plus valid bit, with snoop invalidation.
// Only built when REQUEST_UNIT_ATOMIC_EN is defined.
`ifdef REQUEST_UNIT_ATOMIC_EN
module link_reg
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  set_i,
   input  word_t set_addr_i,
   input  logic  clr_i,
   input  logic  snoop_i,
   input  word_t snoop_addr_i,
   input  word_t cmp_addr_i,
   output logic  match_o
);
   word_t addr_q;
   logic  valid_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else if (set_i) begin
         // An invalidate that hits the address being linked this cycle wins.
         addr_q  <= set_addr_i;
         valid_q <= !(snoop_i && (snoop_addr_i == set_addr_i));
      end else if (clr_i || (snoop_i && (snoop_addr_i == addr_q))) begin
         valid_q <= 1'b0;
      end
   end

   assign match_o = valid_q && (addr_q == cmp_addr_i);
endmodule
`endif

// File: rtl/request_unit.sv
// Turns per-instruction memory control into held cache requests and PC enable.
// Define REQUEST_UNIT_ATOMIC_EN to build the LL/SC link register and sc failure path.
module request_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN,
   input  logic             dWEN,
   input  logic             datomic,
   input  logic             halt,
   input  word_t            daddr,
   input  logic             snoop_inv,
   input  word_t            snoop_addr,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             sc_success,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);
   reqstate_t        state_q, state_d;
   logic             dren_q, dren_d, dwen_q, dwen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             issue, sc_fail;

   assign issue = (state_q == IDLE) && ihit && !halt;

`ifdef REQUEST_UNIT_ATOMIC_EN
   logic is_sc, link_match, store_done, ll_done;
   logic sc_q, sc_d;

   assign is_sc      = datomic && dWEN;
   assign store_done = (state_q == DATA) && dhit && dwen_q;
   assign ll_done    = (state_q == DATA) && dhit && dren_q && datomic;
   assign sc_fail    = issue && is_sc && !link_match;

   link_reg u_link (
      .CLK          (CLK),
      .nRST         (nRST),
      .set_i        (ll_done),
      .set_addr_i   (daddr),
      .clr_i        (sc_fail || (store_done && link_match)),
      .snoop_i      (snoop_inv),
      .snoop_addr_i (snoop_addr),
      .cmp_addr_i   (daddr),
      .match_o      (link_match)
   );

   always_comb begin
      sc_d = sc_q;
      if (issue && is_sc && link_match) sc_d = 1'b1;
      else if ((state_q == DATA) && dhit) sc_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) sc_q <= 1'b0;
      else       sc_q <= sc_d;
   end

   assign sc_success = (state_q == DATA) && sc_q;
`else
   logic unused_snoop;
   assign unused_snoop = snoop_inv ^ (^snoop_addr) ^ (^daddr);
   assign sc_fail      = 1'b0;
   assign sc_success   = pc_en && datomic && dWEN;
`endif

   always_comb begin
      state_d = state_q;
      dren_d  = dren_q;
      dwen_d  = dwen_q;
      cnt_d   = cnt_q;
      imemREN = 1'b0;
      pc_en   = 1'b0;
      case (state_q)
         IDLE: begin
            imemREN = 1'b1;
            if (ihit) begin
               if (halt) begin
                  state_d = HALT;
               end else if (sc_fail) begin
                  pc_en = 1'b1;
               end else if (dREN || dWEN) begin
                  // A simultaneous read and write is illegal; the write is kept.
                  state_d = DATA;
                  dwen_d  = dWEN;
                  dren_d  = dREN && !dWEN;
               end else begin
                  pc_en = 1'b1;
               end
            end
         end
         DATA: begin
            if (dhit) begin
               state_d = IDLE;
               dren_d  = 1'b0;
               dwen_d  = 1'b0;
               pc_en   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HALT: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         dren_q  <= 1'b0;
         dwen_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dren_q  <= dren_d;
         dwen_q  <= dwen_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmemREN   = dren_q;
   assign dmemWEN   = dwen_q;
   assign halted    = (state_q == HALT);
   assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios plus a randomized instruction stream.
module tb_request_unit;
   localparam int CNT_W = 4;
   localparam int SAT   = 15;
`ifdef REQUEST_UNIT_ATOMIC_EN
   localparam bit ATOM = 1'b1;
`else
   localparam bit ATOM = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        nRST, ihit, dhit, dREN, dWEN, datomic, halt, snoop_inv;
   logic [31:0] daddr, snoop_addr;
   logic        imemREN, dmemREN, dmemWEN, pc_en, sc_success, halted;
   logic [CNT_W-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int          m_stall;
   bit          m_lv;
   logic [31:0] m_la;

   request_unit #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
      .datomic(datomic), .halt(halt), .daddr(daddr), .snoop_inv(snoop_inv),
      .snoop_addr(snoop_addr), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .pc_en(pc_en), .sc_success(sc_success), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic idle_inputs();
      ihit = 0; dhit = 0; dREN = 0; dWEN = 0; datomic = 0; halt = 0;
      snoop_inv = 0; daddr = 0; snoop_addr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge CLK); nRST = 0;
      @(negedge CLK); nRST = 1;
      @(posedge CLK); #1;
      m_stall = 0; m_lv = 0; m_la = 0;
   endtask

   // op: 0 nop, 1 lw, 2 sw, 3 ll, 4 sc. snp_at<0 snoops in IDLE before ihit, else on DATA cycle snp_at.
   task automatic do_instr(input int op, input logic [31:0] a, input int idly, input int ddly,
                           input bit snp, input logic [31:0] sa, input int snp_at);
      bit rd, wr, is_sc, ok, acc, exp_sc;
      int w;
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 4);
      is_sc = (op == 4);
      dREN = rd; dWEN = wr; datomic = (op >= 3); daddr = a; halt = 0; snoop_addr = sa;
      w = (snp && snp_at < 0 && idly == 0) ? 1 : idly;
      for (int i = 0; i < w; i++) begin
         ihit = 0; snoop_inv = snp && (snp_at < 0) && (i == 0);
         @(negedge CLK);
         n_cmp++;
         if (imemREN !== 1'b1 || pc_en !== 1'b0) begin
            n_err++; $display("FAIL idle_wait op=%0d imemREN=%b pc_en=%b want 1/0", op, imemREN, pc_en);
         end
         @(posedge CLK); #1;
         if (ATOM && snoop_inv && sa == m_la) m_lv = 0;
      end
      snoop_inv = 0; ihit = 1;
      ok  = !ATOM || !is_sc || (m_lv && m_la == a);
      acc = (op != 0) && ok;
      @(negedge CLK);
      n_cmp++;
      if (pc_en !== !acc || imemREN !== 1'b1) begin
         n_err++; $display("FAIL issue op=%0d pc_en=%b imemREN=%b want %b/1", op, pc_en, imemREN, !acc);
      end
      if (!ok) begin
         n_cmp++;
         if (sc_success !== 1'b0) begin
            n_err++; $display("FAIL sc_fail_flag sc_success=%b want 0", sc_success);
         end
      end
      @(posedge CLK); #1;
      ihit = 0;
      if (!ok) m_lv = 0;
      if (acc) begin
         for (int k = 0; k <= ddly; k++) begin
            dhit = (k == ddly);
            snoop_inv = snp && (snp_at == k);
            exp_sc = is_sc && (ATOM || dhit);
            @(negedge CLK);
            n_cmp++;
            if (imemREN !== 1'b0 || dmemREN !== rd || dmemWEN !== wr || pc_en !== dhit
                || sc_success !== exp_sc) begin
               n_err++;
               $display("FAIL data op=%0d k=%0d got imem=%b ren=%b wen=%b pc=%b sc=%b want 0/%b/%b/%b/%b",
                        op, k, imemREN, dmemREN, dmemWEN, pc_en, sc_success, rd, wr, dhit, exp_sc);
            end
            @(posedge CLK); #1;
            if (!dhit) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (ATOM) begin
               if (dhit && op == 3) begin
                  m_la = a; m_lv = !(snoop_inv && sa == a);
               end else begin
                  if (snoop_inv && sa == m_la) m_lv = 0;
                  if (dhit && wr && a == m_la) m_lv = 0;
               end
            end
         end
      end
      dhit = 0; snoop_inv = 0;
      n_cmp++;
      if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || imemREN !== 1'b1 || stall_cnt !== 4'(m_stall)) begin
         n_err++;
         $display("FAIL retire op=%0d ren=%b wen=%b imem=%b stall=%0d want 0/0/1/%0d",
                  op, dmemREN, dmemWEN, imemREN, stall_cnt, m_stall);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 0;
      #3;
      n_cmp++;
      if (dmemREN !== 0 || dmemWEN !== 0 || halted !== 0 || stall_cnt !== 0 || imemREN !== 1
          || pc_en !== 0 || sc_success !== 0) begin
         n_err++;
         $display("FAIL reset ren=%b wen=%b halted=%b stall=%0d imem=%b pc=%b sc=%b want 0/0/0/0/1/0/0",
                  dmemREN, dmemWEN, halted, stall_cnt, imemREN, pc_en, sc_success);
      end
      do_reset();
   endtask

   task automatic test_lw();
      do_reset();
      do_instr(1, 32'h40, 0, 3, 0, 0, 0);
      do_instr(0, 32'h0, 1, 0, 0, 0, 0);
      do_instr(2, 32'h44, 0, 0, 0, 0, 0);
   endtask

   task automatic test_halt();
      do_reset();
      halt = 1; ihit = 1;
      @(negedge CLK);
      n_cmp++;
      if (pc_en !== 0) begin n_err++; $display("FAIL halt_issue pc_en=%b want 0", pc_en); end
      @(posedge CLK); #1;
      halt = 0; dREN = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (halted !== 1 || imemREN !== 0 || dmemREN !== 0 || pc_en !== 0) begin
            n_err++;
            $display("FAIL halt_hold halted=%b imem=%b ren=%b pc=%b want 1/0/0/0", halted, imemREN, dmemREN, pc_en);
         end
      end
      ihit = 0; dREN = 0;
      nRST = 0; #1;
      n_cmp++;
      if (halted !== 0 || imemREN !== 1) begin
         n_err++; $display("FAIL halt_reset halted=%b imem=%b want 0/1", halted, imemREN);
      end
      do_reset();
   endtask

   task automatic test_atomic();
      do_reset();
      do_instr(3, 32'h100, 0, 1, 0, 0, 0);
      do_instr(4, 32'h100, 0, 2, 0, 0, 0);
      do_instr(4, 32'h100, 0, 1, 0, 0, 0);
      do_instr(3, 32'h100, 0, 0, 0, 0, 0);
      do_instr(4, 32'h100, 2, 1, 1, 32'h100, -1);
      do_instr(3, 32'h100, 0, 0, 0, 0, 0);
      do_instr(4, 32'h100, 2, 1, 1, 32'h104, -1);
      do_instr(3, 32'h100, 0, 2, 1, 32'h100, 2);
      do_instr(4, 32'h100, 0, 0, 0, 0, 0);
      do_instr(3, 32'h100, 0, 0, 0, 0, 0);
      do_instr(2, 32'h100, 0, 0, 0, 0, 0);
      do_instr(4, 32'h100, 0, 0, 0, 0, 0);
      do_instr(3, 32'h108, 0, 0, 0, 0, 0);
      do_instr(4, 32'h108, 0, 3, 1, 32'h108, 1);
   endtask

   task automatic test_reset_mid_data();
      do_reset();
      dWEN = 1; daddr = 32'h200; ihit = 1;
      @(posedge CLK); #1;
      ihit = 0;
      @(negedge CLK);
      n_cmp++;
      if (dmemWEN !== 1 || imemREN !== 0) begin
         n_err++; $display("FAIL mid_data_pre wen=%b imem=%b want 1/0", dmemWEN, imemREN);
      end
      #2 nRST = 0;
      #1;
      n_cmp++;
      if (dmemWEN !== 0 || imemREN !== 1 || stall_cnt !== 0) begin
         n_err++; $display("FAIL mid_data_rst wen=%b imem=%b stall=%0d want 0/1/0", dmemWEN, imemREN, stall_cnt);
      end
      do_reset();
      do_instr(1, 32'h204, 0, 1, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] addrs [3];
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         int op, dd;
         op = int'($urandom_range(0, 4));
         dd = int'($urandom_range(0, 4));
         do_instr(op, addrs[$urandom_range(0, 2)], int'($urandom_range(0, 2)), dd,
                  bit'($urandom_range(0, 1)), addrs[$urandom_range(0, 2)],
                  int'($urandom_range(0, dd + 1)) - 1);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      do_instr(1, 32'h300, 0, (1 << CNT_W) + 5, 0, 0, 0);
      n_cmp++;
      if (stall_cnt !== 4'd15) begin
         n_err++; $display("FAIL saturate stall=%0d want 15", stall_cnt);
      end
      do_instr(2, 32'h304, 0, 2, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_halt();
      test_atomic();
      test_reset_mid_data();
      test_random();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
